// File: rtl/quadrature_decoder.sv
// quadrature_decoder
// Turns a two-phase quadrature pair (A/B) into one-cycle step strobes, a direction
// bit, a wrapping position count and a sticky illegal-transition flag.
// The A/B inputs are asynchronous and pass through two synchronizer flops per channel.
// Optional feature: define QDEC_FILTER_EN to add a per-channel glitch filter that
// passes a new level only after it has been stable for FILTER_LEN cycles.
module quadrature_decoder #(
  parameter int bits       = 16,
  parameter int FILTER_LEN = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            a_in,
  input  logic            b_in,
  input  logic            clear,
  output logic            step,
  output logic            up,
  output logic [bits-1:0] position,
  output logic            err
);

  // Warm-up ends once the synchronizer has flushed its reset value into prev_ab.
  localparam logic [1:0]      WARM_DONE = 2'd3;
  localparam logic [1:0]      DEC_NONE  = 2'd0;
  localparam logic [1:0]      DEC_UP    = 2'd1;
  localparam logic [1:0]      DEC_ILL   = 2'd2;
  localparam logic [1:0]      DEC_DOWN  = 2'd3;
  localparam logic [bits-1:0] POS_ONE   = bits'(1);

  if (FILTER_LEN < 2) begin : g_bad_filter_len
    $error("FILTER_LEN must be at least 2");
  end

  // Position of an {A,B} pair along the up-counting Gray cycle 00,10,11,01.
  function automatic logic [1:0] phase_idx(input logic [1:0] ab);
    return {ab[0], ab[1] ^ ab[0]};
  endfunction

  // Modulo-4 phase distance: 1 = up, 3 = down, 2 = both bits changed, 0 = idle.
  function automatic logic [1:0] classify(input logic [1:0] prev_v, input logic [1:0] cur_v);
    return phase_idx(cur_v) - phase_idx(prev_v);
  endfunction

  // Position update wraps modulo 2^bits in both directions; no saturation.
  function automatic logic [bits-1:0] wrap_step(input logic [bits-1:0] pos, input logic dir);
    return dir ? pos + POS_ONE : pos - POS_ONE;
  endfunction

  logic [1:0] sync_p0;
  logic [1:0] sync_p1;
  logic [1:0] fab;
  logic [1:0] prev_ab;
  logic [1:0] warm_cnt;
  logic       warm_done;
  logic [1:0] dec_cls;
  logic       illegal;

  assign warm_done = (warm_cnt == WARM_DONE);
  assign dec_cls   = classify(prev_ab, fab);
  assign illegal   = warm_done && (dec_cls == DEC_ILL);

  // Stage p0/p1: two-flop synchronizer per channel; sync_p1 is the settled {A,B}.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_p0 <= 2'b00;
      sync_p1 <= 2'b00;
    end else begin
      sync_p0 <= {a_in, b_in};
      sync_p1 <= sync_p0;
    end
  end

  // Warm-up counter: decode stays off until real input levels have reached prev_ab.
  always_ff @(posedge clk) begin
    if (reset) begin
      warm_cnt <= 2'd0;
    end else if (!warm_done) begin
      warm_cnt <= warm_cnt + 2'd1;
    end
  end

`ifdef QDEC_FILTER_EN
  localparam int              CNT_W    = $clog2(FILTER_LEN) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);

  logic [CNT_W-1:0] flt_cnt [2];

  // Stage p2: a channel follows sync_p1 only after FILTER_LEN consecutive differing cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      fab <= 2'b00;
      for (int i = 0; i < 2; i++) flt_cnt[i] <= '0;
    end else if (!warm_done) begin
      fab <= sync_p1;
      for (int i = 0; i < 2; i++) flt_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (sync_p1[i] == fab[i]) begin
          flt_cnt[i] <= '0;
        end else if (flt_cnt[i] == CNT_LAST) begin
          fab[i]     <= sync_p1[i];
          flt_cnt[i] <= '0;
        end else begin
          flt_cnt[i] <= flt_cnt[i] + 1'b1;
        end
      end
    end
  end
`else
  assign fab = sync_p1;
`endif

  // Decode stage: classify fab against prev_ab and update step/up/position/err.
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_ab  <= 2'b00;
      step     <= 1'b0;
      up       <= 1'b0;
      position <= '0;
      err      <= 1'b0;
    end else begin
      step <= 1'b0;
      if (!warm_done) begin
        prev_ab <= sync_p1;
      end else begin
        prev_ab <= fab;
        case (dec_cls)
          DEC_UP: begin
            step     <= 1'b1;
            up       <= 1'b1;
            position <= wrap_step(position, 1'b1);
          end
          DEC_DOWN: begin
            step     <= 1'b1;
            up       <= 1'b0;
            position <= wrap_step(position, 1'b0);
          end
          DEC_NONE, DEC_ILL: ;
        endcase
      end
      // Clear beats a same-cycle step for position; an illegal edge beats clear for err.
      if (clear) begin
        position <= '0;
        err      <= 1'b0;
      end
      if (illegal) begin
        err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_quadrature_decoder.sv
// tb_quadrature_decoder
// Table-driven vectors, hand-written corner sequences and a randomized run checked
// against an event-level reference model of the quadrature decoding rules.
`timescale 1ns/1ps
module tb_quadrature_decoder;

  localparam int BITS    = 16;
  localparam int FL      = 4;
  localparam int POS_MOD = 1 << BITS;
  localparam int HN      = 64;
`ifdef QDEC_FILTER_EN
  localparam int LAT      = 3 + FL;
  localparam int HOLD_MIN = FL;
`else
  localparam int LAT      = 3;
  localparam int HOLD_MIN = 1;
`endif
  localparam int H = LAT + 5;

  logic            clk = 1'b0;
  logic            reset;
  logic            a_in;
  logic            b_in;
  logic            clear;
  logic            step;
  logic            up;
  logic [BITS-1:0] position;
  logic            err;

  int checks   = 0;
  int failures = 0;

  int cyc           = 0;
  int step_cnt      = 0;
  int last_step_cyc = -1;

  logic [1:0] hist     [HN];
  logic       clr_hist [HN];
  logic       model_on = 1'b0;
  int         m_pos;
  logic       m_up;
  logic       m_err;

  logic [1:0] UP_SEQ [4] = '{2'b00, 2'b10, 2'b11, 2'b01};

  typedef struct {
    logic [1:0] ab;
    logic       clr;
    int         exp_steps;
    logic       exp_up;
    int         exp_pos;
    logic       exp_err;
  } vec_t;

  vec_t vecs [14];

  quadrature_decoder #(.bits(BITS), .FILTER_LEN(FL)) dut (
    .clk(clk),
    .reset(reset),
    .a_in(a_in),
    .b_in(b_in),
    .clear(clear),
    .step(step),
    .up(up),
    .position(position),
    .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: time limit reached, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int seq_idx(input logic [1:0] ab);
    int idx = 0;
    for (int i = 0; i < 4; i++) if (UP_SEQ[i] == ab) idx = i;
    return idx;
  endfunction

  function automatic logic [1:0] next_up(input logic [1:0] ab);
    return UP_SEQ[(seq_idx(ab) + 1) % 4];
  endfunction

  function automatic logic [1:0] next_dn(input logic [1:0] ab);
    return UP_SEQ[(seq_idx(ab) + 3) % 4];
  endfunction

  // 0 = no change, 1 = up, 2 = down, 3 = illegal (both phases moved)
  function automatic int classify_ref(input logic [1:0] p, input logic [1:0] c);
    int ip = seq_idx(p);
    int ic = seq_idx(c);
    if (ic == ip) return 0;
    if (ic == (ip + 1) % 4) return 1;
    if (ip == (ic + 1) % 4) return 2;
    return 3;
  endfunction

  task automatic model_check();
    logic [1:0] prv;
    logic [1:0] cur;
    logic       m_step;
    int         kind;
    cur    = hist[(cyc - LAT) % HN];
    prv    = hist[(cyc - LAT - 1) % HN];
    kind   = classify_ref(prv, cur);
    m_step = (kind == 1) || (kind == 2);
    if (kind == 1) begin
      m_up  = 1'b1;
      m_pos = (m_pos + 1) % POS_MOD;
    end else if (kind == 2) begin
      m_up  = 1'b0;
      m_pos = (m_pos + POS_MOD - 1) % POS_MOD;
    end
    if (clr_hist[(cyc - 1) % HN]) begin
      m_pos = 0;
      m_err = 1'b0;
    end
    if (kind == 3) m_err = 1'b1;
    check("rnd_step", step, m_step);
    check("rnd_up", up, m_up);
    check("rnd_position", position, m_pos);
    check("rnd_err", err, m_err);
  endtask

  task automatic tick();
    hist[cyc % HN]     = {a_in, b_in};
    clr_hist[cyc % HN] = clear;
    @(posedge clk);
    #1;
    cyc++;
    if (step === 1'b1) begin
      step_cnt++;
      last_step_cyc = cyc;
    end
    if (model_on) model_check();
  endtask

  task automatic apply(input logic [1:0] ab, input int n);
    {a_in, b_in} = ab;
    clear        = 1'b0;
    repeat (n) tick();
  endtask

  // Drive ab, then assert clear so it is sampled on the edge that registers the decode.
  task automatic edge_with_clear(input logic [1:0] ab);
    {a_in, b_in} = ab;
    repeat (LAT - 1) tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  initial begin
    int         c0;
    logic [1:0] lat_seq  [4];
    logic [1:0] walk_seq [4];

    vecs[0]  = '{2'b10, 1'b0, 1, 1'b1, 1,      1'b0};
    vecs[1]  = '{2'b11, 1'b0, 1, 1'b1, 2,      1'b0};
    vecs[2]  = '{2'b01, 1'b0, 1, 1'b1, 3,      1'b0};
    vecs[3]  = '{2'b00, 1'b0, 1, 1'b1, 4,      1'b0};
    vecs[4]  = '{2'b00, 1'b1, 0, 1'b1, 0,      1'b0};
    vecs[5]  = '{2'b01, 1'b0, 1, 1'b0, 'hFFFF, 1'b0};
    vecs[6]  = '{2'b00, 1'b0, 1, 1'b1, 0,      1'b0};
    vecs[7]  = '{2'b11, 1'b0, 0, 1'b1, 0,      1'b1};
    vecs[8]  = '{2'b01, 1'b0, 1, 1'b1, 1,      1'b1};
    vecs[9]  = '{2'b11, 1'b0, 1, 1'b0, 0,      1'b1};
    vecs[10] = '{2'b10, 1'b0, 1, 1'b0, 'hFFFF, 1'b1};
    vecs[11] = '{2'b10, 1'b1, 0, 1'b0, 0,      1'b0};
    vecs[12] = '{2'b01, 1'b0, 0, 1'b0, 0,      1'b1};
    vecs[13] = '{2'b01, 1'b1, 0, 1'b0, 0,      1'b0};
    lat_seq  = '{2'b00, 2'b10, 2'b11, 2'b01};
    walk_seq = '{2'b11, 2'b01, 2'b00, 2'b10};

    // Reset held three cycles with both phases low.
    reset = 1'b1;
    a_in  = 1'b0;
    b_in  = 1'b0;
    clear = 1'b0;
    repeat (3) tick();
    check("in_reset_step", step, 1'b0);
    check("in_reset_position", position, 0);
    reset = 1'b0;
    tick();
    check("rel_step", step, 1'b0);
    check("rel_up", up, 1'b0);
    check("rel_position", position, 0);
    check("rel_err", err, 1'b0);
    apply(2'b00, 8);

    // Table of single transitions, each held long enough for the decode to settle.
    for (int i = 0; i < 14; i++) begin
      step_cnt     = 0;
      {a_in, b_in} = vecs[i].ab;
      clear        = vecs[i].clr;
      tick();
      clear = 1'b0;
      repeat (H - 1) tick();
      check($sformatf("vec%0d_steps", i), step_cnt, vecs[i].exp_steps);
      check($sformatf("vec%0d_up", i), up, vecs[i].exp_up);
      check($sformatf("vec%0d_position", i), position, vecs[i].exp_pos);
      check($sformatf("vec%0d_err", i), err, vecs[i].exp_err);
    end

    // Up cycle from 01: each pulse is one cycle wide and LAT edges after the change.
    for (int i = 0; i < 4; i++) begin
      step_cnt      = 0;
      last_step_cyc = -1;
      c0            = cyc;
      apply(lat_seq[i], LAT + 4);
      check($sformatf("lat%0d_pulses", i), step_cnt, 1);
      check($sformatf("lat%0d_edges", i), last_step_cyc - c0, LAT);
    end
    check("upseq_position", position, 4);
    check("upseq_up", up, 1'b1);

    // 01 -> 10 moves both phases at once.
    step_cnt = 0;
    apply(2'b10, H);
    check("ill_err", err, 1'b1);
    check("ill_steps", step_cnt, 0);
    check("ill_position", position, 4);

    // Clear on the same edge as a valid up step: clear wins for position.
    edge_with_clear(2'b11);
    check("clr_step_step", step, 1'b1);
    check("clr_step_position", position, 0);
    check("clr_step_err", err, 1'b0);
    check("clr_step_up", up, 1'b1);
    apply(2'b11, H);

    // Clear on the same edge as an illegal transition: err stays set.
    edge_with_clear(2'b00);
    check("clr_ill_err", err, 1'b1);
    check("clr_ill_step", step, 1'b0);
    check("clr_ill_position", position, 0);
    apply(2'b00, H);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    tick();
    check("clr_only_err", err, 1'b0);

    // Walk to position 5 resting on 11, then reset in the middle of operation.
    apply(2'b10, H);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    for (int i = 0; i < 4; i++) apply(walk_seq[i], H);
    apply(2'b11, H);
    check("walk_position", position, 5);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_rst_step", step, 1'b0);
    check("mid_rst_up", up, 1'b0);
    check("mid_rst_position", position, 0);
    check("mid_rst_err", err, 1'b0);
    step_cnt = 0;
    apply(2'b11, LAT + 6);
    check("mid_rel_steps", step_cnt, 0);
    check("mid_rel_err", err, 1'b0);
    check("mid_rel_position", position, 0);
    step_cnt = 0;
    apply(2'b01, H);
    check("mid_next_position", position, 1);
    check("mid_next_up", up, 1'b1);
    check("mid_next_steps", step_cnt, 1);

`ifdef QDEC_FILTER_EN
    // A high for two cycles only.
    step_cnt = 0;
    apply(2'b11, 2);
    apply(2'b01, 20);
    check("flt_short_steps", step_cnt, 0);
    check("flt_short_err", err, 1'b0);
    // A high held: one step, FILTER_LEN edges later than the unfiltered path.
    step_cnt      = 0;
    last_step_cyc = -1;
    c0            = cyc;
    apply(2'b11, LAT + 4);
    check("flt_hold_pulses", step_cnt, 1);
    check("flt_hold_edges", last_step_cyc - c0, 3 + FL);
    // A toggling every cycle never settles long enough to pass.
    step_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      a_in = ~a_in;
      tick();
    end
    apply({a_in, b_in}, 20);
    check("flt_toggle_steps", step_cnt, 0);
    check("flt_toggle_err", err, 1'b0);
`endif

    // Randomized run: start from a known up step taken together with a clear.
    clear        = 1'b1;
    {a_in, b_in} = next_up({a_in, b_in});
    tick();
    clear = 1'b0;
    repeat (LAT + 3) tick();
    check("rnd_start_position", position, 1);
    check("rnd_start_up", up, 1'b1);
    m_pos    = 1;
    m_up     = 1'b1;
    m_err    = 1'b0;
    model_on = 1'b1;
    for (int r = 0; r < 300; r++) begin
      int         sel;
      logic [1:0] cur;
      logic [1:0] nxt;
      sel = $urandom_range(0, 99);
      cur = {a_in, b_in};
      if (sel < 45)      nxt = next_up(cur);
      else if (sel < 90) nxt = next_dn(cur);
      else if (sel < 95) nxt = ~cur;
      else               nxt = cur;
      {a_in, b_in} = nxt;
      clear        = ($urandom_range(0, 19) == 0);
      tick();
      clear = 1'b0;
      repeat ($urandom_range(0, 3) + HOLD_MIN - 1) tick();
    end
    apply({a_in, b_in}, LAT + 3);
    model_on = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
